// File: rtl/lsu_mem_stage_if.sv
// Memory-side bus of the load/store unit memory stage.
// The master (the LSU) issues one request and waits for one response.
// Signal suffixes are taken from the LSU's point of view.
interface lsu_mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_we_o;
  logic [3:0]        mem_wstrb_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_rsp_valid_i;
  logic [31:0]       mem_rdata_i;

  modport master (
    output mem_req_valid_o,
    output mem_addr_o,
    output mem_we_o,
    output mem_wstrb_o,
    output mem_wdata_o,
    input  mem_req_ready_i,
    input  mem_rsp_valid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_valid_o,
    input  mem_addr_o,
    input  mem_we_o,
    input  mem_wstrb_o,
    input  mem_wdata_o,
    output mem_req_ready_i,
    output mem_rsp_valid_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store unit memory stage: accepts one LOAD/STORE at a time, issues a
// single word-aligned memory request, and returns an extended load result
// with fault flags.
// Optional feature macro: LSU_MISALIGN_EXC_EN. When defined, misaligned
// half/word accesses fault without touching memory; otherwise they are
// forced to natural alignment and proceed.
module lsu_mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               is_store_i,
  input  logic [2:0]         funct3_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [31:0]        wdata_i,
  output logic               resp_valid_o,
  output logic [31:0]        rdata_o,
  output logic               misaligned_o,
  output logic               illegal_o,
  lsu_mem_stage_if.master    mem
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        illegal_q;
  logic        mis_q;

  logic [1:0]  size_d;
  logic [1:0]  off_d;
  logic        illegal_d;
  logic        mis_fault_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;

  // Select and extend the addressed lane of a returned memory word.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = 32'(b);
      3'b100:  r = {24'd0, b};
      3'b001:  r = 32'(h);
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Decode the offered operation: legality, alignment, lane offset and write lanes.
  always_comb begin
    size_d    = funct3_i[1:0];
    illegal_d = is_store_i ? (funct3_i[2] | (funct3_i[1:0] == 2'b11))
                           : ((funct3_i[1:0] == 2'b11) | (funct3_i[2:1] == 2'b11));
`ifdef LSU_MISALIGN_EXC_EN
    // Misalignment only matters for legal operations; illegal ones fault first.
    mis_fault_d = ~illegal_d &
                  (((size_d == 2'b01) & addr_i[0]) |
                   ((size_d == 2'b10) & (addr_i[1:0] != 2'b00)));
`else
    mis_fault_d = 1'b0;
`endif
    // Natural alignment: halves drop bit 0, words use lane 0.
    case (size_d)
      2'b01:   off_d = {addr_i[1], 1'b0};
      2'b10:   off_d = 2'b00;
      default: off_d = addr_i[1:0];
    endcase
    wstrb_d = 4'b0000;
    wdata_d = 32'd0;
    if (is_store_i) begin
      case (size_d)
        2'b00: begin
          wstrb_d = 4'b0001 << off_d;
          wdata_d = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          wstrb_d = 4'b0011 << off_d;
          wdata_d = {2{wdata_i[15:0]}};
        end
        default: begin
          wstrb_d = 4'b1111;
          wdata_d = wdata_i;
        end
      endcase
    end
  end

  // Operation FSM with registered handshake, memory and result outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q              <= S_IDLE;
      req_ready_o          <= 1'b1;
      resp_valid_o         <= 1'b0;
      rdata_o              <= 32'd0;
      misaligned_o         <= 1'b0;
      illegal_o            <= 1'b0;
      mem.mem_req_valid_o  <= 1'b0;
      mem.mem_addr_o       <= '0;
      mem.mem_we_o         <= 1'b0;
      mem.mem_wstrb_o      <= 4'b0000;
      mem.mem_wdata_o      <= 32'd0;
      is_store_q           <= 1'b0;
      funct3_q             <= 3'd0;
      off_q                <= 2'd0;
      illegal_q            <= 1'b0;
      mis_q                <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            is_store_q   <= is_store_i;
            funct3_q     <= funct3_i;
            off_q        <= off_d;
            illegal_q    <= illegal_d;
            mis_q        <= mis_fault_d;
            req_ready_o  <= 1'b0;
            rdata_o      <= 32'd0;
            illegal_o    <= 1'b0;
            misaligned_o <= 1'b0;
            if (illegal_d || mis_fault_d) begin
              state_q <= S_RESP;
            end else begin
              state_q             <= S_REQ;
              mem.mem_req_valid_o <= 1'b1;
              mem.mem_addr_o      <= {addr_i[ADDR_W-1:2], 2'b00};
              mem.mem_we_o        <= is_store_i;
              mem.mem_wstrb_o     <= wstrb_d;
              mem.mem_wdata_o     <= wdata_d;
            end
          end
        end
        S_REQ: begin
          if (mem.mem_req_ready_i) begin
            mem.mem_req_valid_o <= 1'b0;
            state_q             <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The result is formed as the response arrives, so RESP opens with the pulse.
          if (mem.mem_rsp_valid_i) begin
            resp_valid_o <= 1'b1;
            rdata_o      <= is_store_q ? 32'd0 : load_extract(funct3_q, off_q, mem.mem_rdata_i);
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          // Faulting operations arrive here without a pulse and raise it one cycle later.
          if (!resp_valid_o) begin
            resp_valid_o <= 1'b1;
            illegal_o    <= illegal_q;
            misaligned_o <= mis_q;
            rdata_o      <= 32'd0;
          end else begin
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a response scoreboard.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        resp_valid_o;
  logic [31:0] rdata_o;
  logic        misaligned_o;
  logic        illegal_o;

  always #5 clk = ~clk;

  lsu_mem_stage_if #(.ADDR_W(32)) mif ();

  lsu_mem_stage #(.ADDR_W(32)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .is_store_i   (is_store_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .resp_valid_o (resp_valid_o),
    .rdata_o      (rdata_o),
    .misaligned_o (misaligned_o),
    .illegal_o    (illegal_o),
    .mem          (mif)
  );

`ifdef LSU_MISALIGN_EXC_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        ill;
    logic        mis;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete operation; expected response is queued at the accept.
  task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                        input int stall, input int dly, input logic byp,
                        input logic [31:0] e_addr, input logic [3:0] e_strb,
                        input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                        input logic e_ill, input logic e_mis);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk({tag, " ready_idle"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    is_store_i  = st;
    funct3_i    = f3;
    addr_i      = a;
    wdata_i     = wd;
    sb.push_back('{rdata: e_rdata, ill: e_ill, mis: e_mis, lat: (byp ? 2 : 3 + stall + dly)});
    @(negedge clk);
    lat = 1;
    // Keep offering garbage while busy; it must be ignored.
    is_store_i = ~st;
    funct3_i   = 3'b000;
    addr_i     = $urandom;
    wdata_i    = $urandom;
    chk({tag, " ready_busy"}, 32'(req_ready_o), 32'd0);
    if (byp) begin
      chk({tag, " no_mem_req"}, 32'(mif.mem_req_valid_o), 32'd0);
    end else begin
      chk({tag, " req_valid"}, 32'(mif.mem_req_valid_o), 32'd1);
      chk({tag, " addr"}, mif.mem_addr_o, e_addr);
      chk({tag, " we"}, 32'(mif.mem_we_o), 32'(st));
      chk({tag, " wstrb"}, 32'(mif.mem_wstrb_o), 32'(e_strb));
      if (st) chk({tag, " wdata"}, mif.mem_wdata_o, e_wdata);
      for (int i = 0; i < stall; i++) begin
        mif.mem_req_ready_i = 1'b0;
        @(negedge clk);
        lat++;
        chk({tag, " stall_valid"}, 32'(mif.mem_req_valid_o), 32'd1);
        chk({tag, " stall_addr"}, mif.mem_addr_o, e_addr);
        chk({tag, " stall_ready"}, 32'(req_ready_o), 32'd0);
      end
      mif.mem_req_ready_i = 1'b1;
      @(negedge clk);
      lat++;
      mif.mem_req_ready_i = 1'b0;
      chk({tag, " req_drop"}, 32'(mif.mem_req_valid_o), 32'd0);
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        lat++;
        chk({tag, " resp_early"}, 32'(resp_valid_o), 32'd0);
      end
      mif.mem_rsp_valid_i = 1'b1;
      mif.mem_rdata_i     = mrd;
      @(negedge clk);
      lat++;
      mif.mem_rsp_valid_i = 1'b0;
      mif.mem_rdata_i     = $urandom;
    end
    while (!resp_valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    req_valid_i = 1'b0;
    chk({tag, " resp_valid"}, 32'(resp_valid_o), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, " rdata"}, rdata_o, e.rdata);
      chk({tag, " illegal"}, 32'(illegal_o), 32'(e.ill));
      chk({tag, " misaligned"}, 32'(misaligned_o), 32'(e.mis));
      chk({tag, " latency"}, 32'(lat), 32'(e.lat));
      chk({tag, " ready_resp"}, 32'(req_ready_o), 32'd0);
    end
    @(negedge clk);
    chk({tag, " pulse_end"}, 32'(resp_valid_o), 32'd0);
    chk({tag, " ready_back"}, 32'(req_ready_o), 32'd1);
    chk({tag, " rdata_hold"}, rdata_o, e.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    reset_i             = 1'b1;
    req_valid_i         = 1'b0;
    is_store_i          = 1'b0;
    funct3_i            = 3'd0;
    addr_i              = 32'd0;
    wdata_i             = 32'd0;
    mif.mem_req_ready_i = 1'b0;
    mif.mem_rsp_valid_i = 1'b0;
    mif.mem_rdata_i     = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset ready", 32'(req_ready_o), 32'd1);
    chk("reset resp_valid", 32'(resp_valid_o), 32'd0);
    chk("reset rdata", rdata_o, 32'd0);
    chk("reset flags", {30'd0, misaligned_o, illegal_o}, 32'd0);
    chk("reset mem_req", 32'(mif.mem_req_valid_o), 32'd0);
    chk("reset mem_addr", mif.mem_addr_o, 32'd0);
    chk("reset mem_we_strb", {27'd0, mif.mem_we_o, mif.mem_wstrb_o}, 32'd0);
    chk("reset mem_wdata", mif.mem_wdata_o, 32'd0);
    reset_i = 1'b0;

    //      tag      st    f3      addr      wdata         mem rdata     stl dly byp
    run_op("LB_103", 1'b0, 3'b000, 32'h103, 32'h0,        32'h80AABBCC, 0, 0, 1'b0,
           32'h100, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
    run_op("SH_202", 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hDEADBEEF, 0, 0, 1'b0,
           32'h200, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 1'b0);
    run_op("LW_301", 1'b0, 3'b010, 32'h301, 32'h0,        32'h11223344, 0, 0, MIS_EN,
           32'h300, 4'b0000, 32'h0, MIS_EN ? 32'h0 : 32'h11223344, 1'b0, MIS_EN);
    run_op("LW_stall", 1'b0, 3'b010, 32'h504, 32'h0,      32'hCAFEF00D, 5, 2, 1'b0,
           32'h504, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
    run_op("LD_f110", 1'b0, 3'b110, 32'h010, 32'h0,       32'h0,        0, 0, 1'b1,
           32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0);
    run_op("LBU_102", 1'b0, 3'b100, 32'h102, 32'h0,       32'h80AABBCC, 0, 1, 1'b0,
           32'h100, 4'b0000, 32'h0, 32'h000000AA, 1'b0, 1'b0);
    run_op("LB_101", 1'b0, 3'b000, 32'h101, 32'h0,        32'h12345678, 1, 0, 1'b0,
           32'h100, 4'b0000, 32'h0, 32'h00000056, 1'b0, 1'b0);
    run_op("LHU_106", 1'b0, 3'b101, 32'h106, 32'h0,       32'h80AABBCC, 0, 0, 1'b0,
           32'h104, 4'b0000, 32'h0, 32'h000080AA, 1'b0, 1'b0);
    run_op("LH_000", 1'b0, 3'b001, 32'h000, 32'h0,        32'h80AABBCC, 0, 0, 1'b0,
           32'h000, 4'b0000, 32'h0, 32'hFFFFBBCC, 1'b0, 1'b0);
    run_op("SB_011", 1'b1, 3'b000, 32'h011, 32'h00000055, 32'h0,        0, 0, 1'b0,
           32'h010, 4'b0010, 32'h55555555, 32'h0, 1'b0, 1'b0);
    run_op("SW_020", 1'b1, 3'b010, 32'h020, 32'hA5A50F0F, 32'h0,        2, 0, 1'b0,
           32'h020, 4'b1111, 32'hA5A50F0F, 32'h0, 1'b0, 1'b0);
    run_op("ST_f111", 1'b1, 3'b111, 32'h040, 32'h12345678, 32'h0,       0, 0, 1'b1,
           32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0);
    run_op("LD_f011", 1'b0, 3'b011, 32'h040, 32'h0,       32'h0,        0, 0, 1'b1,
           32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0);
    run_op("SH_203", 1'b1, 3'b001, 32'h203, 32'h0000BEEF, 32'h0,        0, 0, MIS_EN,
           32'h200, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b0, MIS_EN);
    run_op("LH_107", 1'b0, 3'b001, 32'h107, 32'h0,        32'h80AABBCC, 0, 0, MIS_EN,
           32'h104, 4'b0000, 32'h0, MIS_EN ? 32'h0 : 32'hFFFF80AA, 1'b0, MIS_EN);

    // Reset while waiting for the response, then a stale response.
    @(negedge clk);
    req_valid_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h400;
    @(negedge clk);
    req_valid_i = 1'b0;
    mif.mem_req_ready_i = 1'b1;
    @(negedge clk);
    mif.mem_req_ready_i = 1'b0;
    reset_i = 1'b1;
    mif.mem_rsp_valid_i = 1'b1;
    mif.mem_rdata_i = 32'h77777777;
    @(negedge clk);
    reset_i = 1'b0;
    chk("rstwait ready", 32'(req_ready_o), 32'd1);
    chk("rstwait resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rstwait rdata", rdata_o, 32'd0);
    chk("rstwait mem_req", 32'(mif.mem_req_valid_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mif.mem_rsp_valid_i = 1'b0;
      chk("rstwait stray_resp", 32'(resp_valid_o), 32'd0);
      chk("rstwait stray_ready", 32'(req_ready_o), 32'd1);
    end

    // Reset in REQ together with a memory grant and a new offer.
    @(negedge clk);
    req_valid_i = 1'b1; is_store_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h600; wdata_i = 32'h1;
    @(negedge clk);
    chk("rstreq in_req", 32'(mif.mem_req_valid_o), 32'd1);
    reset_i = 1'b1;
    mif.mem_req_ready_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    mif.mem_req_ready_i = 1'b0;
    req_valid_i = 1'b0;
    chk("rstreq ready", 32'(req_ready_o), 32'd1);
    chk("rstreq mem_req", 32'(mif.mem_req_valid_o), 32'd0);
    chk("rstreq mem_we", 32'(mif.mem_we_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstreq no_resp", 32'(resp_valid_o), 32'd0);
    end

    run_op("LBU_after", 1'b0, 3'b100, 32'h703, 32'h0,     32'h80AABBCC, 0, 0, 1'b0,
           32'h700, 4'b0000, 32'h0, 32'h00000080, 1'b0, 1'b0);
    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of addr_i and mem_addr_o.
REQ-002 SHALL have one clock and synchronous active-high reset: clk_i input 1, rising-edge clock for all state.
REQ-003 reset_i  input  1  synchronous active-high reset.
REQ-004 req_valid_i  input  1  execute stage offers a LOAD/STORE operation.
REQ-005 req_ready_o  output  1  stage can accept an operation.
REQ-006 is_store_i  input  1  1 = STORE opcode, 0 = LOAD opcode.
REQ-007 funct3_i  input  3  LB/LH/LW/LBU/LHU or SB/SH/SW encoding.
REQ-008 addr_i  input  ADDR_W  effective byte address.
REQ-009 wdata_i  input  32  store data, right-aligned.
REQ-010 resp_valid_o  output  1  one-cycle completion pulse.
REQ-011 rdata_o  output  32  extended load result; 0 for stores and faults.
REQ-012 misaligned_o / illegal_o  output  1 each  fault flags, valid with resp_valid_o.
REQ-013 mem_req_valid_o, mem_req_ready_i  out/in  1  memory request handshake.
REQ-014 mem_addr_o  output  ADDR_W  word-aligned address, low two bits always 0.
REQ-015 mem_we_o  output  1, mem_wstrb_o  output  4, mem_wdata_o  output  32  write controls.
REQ-016 mem_rsp_valid_i  input  1, mem_rdata_i  input  32  memory response, one per accepted request.

Function
REQ-017 SHALL implement FSM IDLE -> REQ -> WAIT -> RESP -> IDLE; req_ready_o = 1 only in IDLE.
REQ-018 SHALL latch is_store_i, funct3_i, addr_i and wdata_i on req_valid_i & req_ready_o, and ignore inputs at all other times.
REQ-019 SHALL move IDLE -> RESP directly, with no memory request, for illegal funct3 (load 011/110/111, store 011-111), setting illegal_o = 1.
REQ-020 In REQ, SHALL hold mem_req_valid_o = 1 with stable address/we/wstrb/wdata until mem_req_ready_i = 1, then move to WAIT.
REQ-021 In WAIT, SHALL capture mem_rdata_i on mem_rsp_valid_i = 1 and move to RESP; mem_rsp_valid_i outside WAIT SHALL be ignored.
REQ-022 In RESP, SHALL assert resp_valid_o for exactly one cycle, then return to IDLE; minimum accept-to-resp_valid_o latency with zero memory wait is 3 cycles.
REQ-023 Store lanes: SB wstrb = 0001 << addr[1:0] with byte replicated x4; SH wstrb = 0011 << addr[1:0] with half replicated x2; SW wstrb = 1111.
REQ-024 Loads: SHALL select the byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through; mem_we_o = 0, mem_wstrb_o = 0000.
REQ-025 Misaligned: half with addr[0] = 1, or word with addr[1:0] != 00; handling SHALL follow REQ-030/031.
REQ-026 Outputs SHALL be registered; rdata_o and fault flags SHALL hold until the next accept.

Reset
REQ-027 reset_i SHALL force IDLE and drive req_ready_o = 1 and all other outputs to 0 in the following cycle.
REQ-028 Reset during REQ or WAIT SHALL abandon the operation, with no resp_valid_o; a later stale mem_rsp_valid_i SHALL be ignored.
REQ-029 Reset SHALL take priority over a simultaneous accept or memory response.

Configuration
REQ-030 With LSU_MISALIGN_EXC_EN defined, a misaligned access SHALL go IDLE -> RESP with misaligned_o = 1, rdata_o = 0 and no memory request.
REQ-031 Without LSU_MISALIGN_EXC_EN, misaligned_o SHALL stay 0 and the access SHALL proceed with addr[1:0] forced to the natural alignment (LH/SH clear bit 0, LW/SW clear bits 1:0).

Verification
REQ-032 LB at addr 0x103, mem_rdata_i = 0x80AABBCC -> mem_addr_o = 0x100, rdata_o = 0xFFFFFF80, illegal_o = misaligned_o = 0.
REQ-033 SH at 0x202 with wdata_i = 0x1234ABCD -> mem_wstrb_o = 1100, mem_wdata_o = 0xABCDABCD, mem_we_o = 1, rdata_o = 0.
REQ-034 LW at 0x301 -> with EN: resp 2 cycles after accept, misaligned_o = 1, no mem_req_valid_o; without EN: mem_addr_o = 0x300.
REQ-035 mem_req_ready_i held low 5 cycles, then rsp 2 cycles later -> address stable throughout, single resp_valid_o pulse, req_ready_o low until IDLE.
REQ-036 Load funct3 = 110 -> illegal_o = 1 with no memory request; reset in WAIT followed by a stray mem_rsp_valid_i -> no resp_valid_o, req_ready_o = 1.
